// File: rtl/dp_mem_arb.sv
// dp_mem_arb: dual-port register-array memory with byte strobes, range errors and fair write-collision arbitration
// Ports (A shown, B identical with b_ prefix):
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   a_valid      request valid; accepted when not blocked by a collision
//   a_wr_rd      1 = write, 0 = read
//   a_addr       word address (AW bits)
//   a_wdata      write data (DW bits)
//   a_wstrb      byte write enables (DW/8 bits)
//   a_rdata      read data, held until the next read response on this port
//   a_ready      one-cycle response pulse, the cycle after acceptance
//   a_err        address-out-of-range flag, qualified by a_ready
// Build option: DP_MEM_BYPASS_EN selects write-first forwarding for a read that
// meets the other port's write to the same address; default is read-first.
module dp_mem_arb #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic            a_wr_rd,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_wdata,
    input  logic [DW/8-1:0] a_wstrb,
    output logic [DW-1:0]   a_rdata,
    output logic            a_ready,
    output logic            a_err,
    input  logic            b_valid,
    input  logic            b_wr_rd,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_wdata,
    input  logic [DW/8-1:0] b_wstrb,
    output logic [DW-1:0]   b_rdata,
    output logic            b_ready,
    output logic            b_err
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = DW / 8;

    logic [DW-1:0] mem [DEPTH];
    logic          prio;
    logic          a_ok, b_ok, coll, a_acc, b_acc, a_we, b_we;
    logic [IW-1:0] a_idx, b_idx;
    logic [DW-1:0] a_rd, b_rd;

    assign a_ok  = {1'b0, a_addr} < (AW+1)'(DEPTH);
    assign b_ok  = {1'b0, b_addr} < (AW+1)'(DEPTH);
    assign a_idx = a_addr[IW-1:0];
    assign b_idx = b_addr[IW-1:0];
    // Only in-range same-address write pairs contend; error addresses never block.
    assign coll  = a_valid & b_valid & a_wr_rd & b_wr_rd & a_ok & (a_addr == b_addr);
    // prio = 0 lets A through on a collision, prio = 1 lets B through.
    assign a_acc = a_valid & ~(coll & prio);
    assign b_acc = b_valid & ~(coll & ~prio);
    assign a_we  = a_acc & a_wr_rd & a_ok;
    assign b_we  = b_acc & b_wr_rd & b_ok;

    always_comb begin
        a_rd = a_ok ? mem[a_idx] : '0;
        b_rd = b_ok ? mem[b_idx] : '0;
`ifdef DP_MEM_BYPASS_EN
        // Merge the other port's strobed bytes into a same-cycle read of the same word.
        for (int i = 0; i < SW; i++) begin
            if (b_we && a_ok && a_addr == b_addr && b_wstrb[i]) a_rd[8*i +: 8] = b_wdata[8*i +: 8];
            if (a_we && b_ok && a_addr == b_addr && a_wstrb[i]) b_rd[8*i +: 8] = a_wdata[8*i +: 8];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else begin
            for (int i = 0; i < SW; i++) begin
                if (a_we && a_wstrb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                if (b_we && b_wstrb[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio    <= 1'b0;
            a_ready <= 1'b0;
            a_err   <= 1'b0;
            a_rdata <= '0;
            b_ready <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
        end else begin
            prio    <= coll ? ~prio : prio;
            a_ready <= a_acc;
            a_err   <= a_acc & ~a_ok;
            a_rdata <= (a_acc && !a_wr_rd) ? a_rd : a_rdata;
            b_ready <= b_acc;
            b_err   <= b_acc & ~b_ok;
            b_rdata <= (b_acc && !b_wr_rd) ? b_rd : b_rdata;
        end
    end
endmodule

// File: tb/tb_dp_mem_arb.sv
// tb_dp_mem_arb: directed self-checking bench for dp_mem_arb
module tb_dp_mem_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, a_wr_rd = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [3:0]  a_wstrb = '0;
    logic [31:0] a_rdata;
    logic        a_ready, a_err;
    logic        b_valid = 1'b0, b_wr_rd = 1'b0;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_wstrb = '0;
    logic [31:0] b_rdata;
    logic        b_ready, b_err;
    int          checks = 0;
    int          errors = 0;
`ifdef DP_MEM_BYPASS_EN
    localparam logic [31:0] RW_EXP = 32'h99;
`else
    localparam logic [31:0] RW_EXP = 32'h55;
`endif

    always #5 clk = ~clk;

    dp_mem_arb dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_wr_rd(a_wr_rd), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_wstrb(a_wstrb), .a_rdata(a_rdata), .a_ready(a_ready), .a_err(a_err),
        .b_valid(b_valid), .b_wr_rd(b_wr_rd), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_wstrb(b_wstrb), .b_rdata(b_rdata), .b_ready(b_ready), .b_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic v, input logic wr, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] s);
        a_valid = v; a_wr_rd = wr; a_addr = ad; a_wdata = d; a_wstrb = s;
    endtask

    task automatic b_req(input logic v, input logic wr, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] s);
        b_valid = v; b_wr_rd = wr; b_addr = ad; b_wdata = d; b_wstrb = s;
    endtask

    initial begin
        step();
        step();
        chk("rst_a_ready", {31'b0, a_ready}, 0);
        chk("rst_b_ready", {31'b0, b_ready}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_err", {31'b0, b_err}, 0);
        rst = 1'b1;
        step();

        // Byte strobes
        a_req(1, 1, 2, 32'hAABBCCDD, 4'b1111);
        step();
        chk("strb_w1_ready", {31'b0, a_ready}, 1);
        a_req(1, 1, 2, 32'h11223344, 4'b0101);
        step();
        chk("strb_w2_ready", {31'b0, a_ready}, 1);
        chk("strb_w2_err", {31'b0, a_err}, 0);
        a_req(0, 0, 0, 0, 0);
        b_req(1, 0, 2, 0, 0);
        step();
        chk("strb_idle_a", {31'b0, a_ready}, 0);
        chk("strb_rd_ready", {31'b0, b_ready}, 1);
        chk("strb_rd_data", b_rdata, 32'hAA22CC44);
        b_req(0, 0, 0, 0, 0);

        // Collision fairness, round 1 (A has priority)
        a_req(1, 1, 5, 32'h1, 4'hF);
        b_req(1, 1, 5, 32'h2, 4'hF);
        step();
        chk("col1_a_ready", {31'b0, a_ready}, 1);
        chk("col1_b_blocked", {31'b0, b_ready}, 0);
        a_req(0, 0, 0, 0, 0);
        step();
        chk("col1_b_ready", {31'b0, b_ready}, 1);
        chk("col1_a_quiet", {31'b0, a_ready}, 0);
        b_req(0, 0, 0, 0, 0);
        a_req(1, 0, 5, 0, 0);
        step();
        chk("col1_word", a_rdata, 32'h2);

        // Round 2 (B has priority now)
        a_req(1, 1, 5, 32'h3, 4'hF);
        b_req(1, 1, 5, 32'h4, 4'hF);
        step();
        chk("col2_b_ready", {31'b0, b_ready}, 1);
        chk("col2_a_blocked", {31'b0, a_ready}, 0);
        b_req(0, 0, 0, 0, 0);
        step();
        chk("col2_a_ready", {31'b0, a_ready}, 1);
        a_req(1, 0, 5, 0, 0);
        step();
        chk("col2_word", a_rdata, 32'h3);

        // Different-address writes are both accepted and leave prio at A
        a_req(1, 1, 8, 32'h8, 4'hF);
        b_req(1, 1, 9, 32'h9, 4'hF);
        step();
        chk("diff_a_ready", {31'b0, a_ready}, 1);
        chk("diff_b_ready", {31'b0, b_ready}, 1);
        a_req(1, 1, 10, 32'hA0, 4'hF);
        b_req(1, 1, 10, 32'hB0, 4'hF);
        step();
        chk("col3_a_wins", {31'b0, a_ready}, 1);
        chk("col3_b_blocked", {31'b0, b_ready}, 0);
        a_req(0, 0, 0, 0, 0);
        step();
        b_req(0, 0, 0, 0, 0);

        // Read/write same address
        a_req(1, 1, 7, 32'h55, 4'hF);
        step();
        a_req(1, 1, 7, 32'h99, 4'hF);
        b_req(1, 0, 7, 0, 0);
        step();
        chk("rw_a_ready", {31'b0, a_ready}, 1);
        chk("rw_b_ready", {31'b0, b_ready}, 1);
        chk("rw_b_rdata", b_rdata, RW_EXP);
        b_req(1, 1, 12, 32'hDEAD, 4'hF);
        a_req(1, 0, 7, 0, 0);
        step();
        chk("rw_a_rdata", a_rdata, 32'h99);
        chk("wr_keeps_rdata", b_rdata, RW_EXP);
        b_req(0, 0, 0, 0, 0);

        // Out of range (addr 20 aliases word 4 if the range check is lost)
        a_req(1, 1, 20, 32'hFFFFFFFF, 4'hF);
        step();
        chk("oor_w_ready", {31'b0, a_ready}, 1);
        chk("oor_w_err", {31'b0, a_err}, 1);
        chk("oor_w_rdata_kept", a_rdata, 32'h99);
        a_req(1, 0, 20, 0, 0);
        b_req(1, 0, 4, 0, 0);
        step();
        chk("oor_r_err", {31'b0, a_err}, 1);
        chk("oor_r_rdata", a_rdata, 0);
        chk("oor_mem4", b_rdata, 0);
        chk("inr_b_err", {31'b0, b_err}, 0);
        a_req(1, 1, 20, 32'h1, 4'hF);
        b_req(1, 1, 20, 32'h2, 4'hF);
        step();
        chk("oor_col_a", {30'b0, a_ready, a_err}, 3);
        chk("oor_col_b", {30'b0, b_ready, b_err}, 3);
        b_req(0, 0, 0, 0, 0);

        // Throughput: fill then read back on consecutive cycles
        for (int i = 0; i < 16; i++) begin
            a_req(1, 1, 5'(i), 32'h1000_0000 + i, 4'hF);
            step();
            chk("fill_ready", {31'b0, a_ready}, 1);
        end
        for (int i = 0; i < 16; i++) begin
            a_req(1, 0, 5'(i), 0, 0);
            step();
            chk("tp_ready", {31'b0, a_ready}, 1);
            chk("tp_data", a_rdata, 32'h1000_0000 + i);
        end

        // Reset mid-stream with a pending ready
        a_req(1, 0, 3, 0, 0);
        step();
        chk("pre_rst_ready", {31'b0, a_ready}, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, a_ready}, 0);
        chk("mid_rst_rdata", a_rdata, 0);
        chk("mid_rst_err", {31'b0, a_err}, 0);
        a_req(0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        step();
        chk("post_rst_quiet", {31'b0, a_ready}, 0);
        a_req(1, 0, 3, 0, 0);
        step();
        chk("post_rst_ready", {31'b0, a_ready}, 1);
        chk("post_rst_data", a_rdata, 0);
        a_req(0, 0, 0, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
